// File: rtl/sys_irq_ctrl.sv
// sys_irq_ctrl: system control register, joypad port, one-shot countdown
// timer with a selectable prescaler, and a two-source interrupt status
// block (timer expiry and audio DMA completion) with per-source enables.
//
// Register map (CPU offsets within the 2020-2027 window):
//   0 R  : inverted joypad state (buttons read active-low on the bus)
//   3 RW : timer count; write non-zero starts a countdown, write zero
//          raises the timer event immediately
//   4 R  : acknowledge timer event (read side effect only)
//   5 R  : acknowledge DMA event (read side effect only)
//   6 RW : sys_ctl {-, bank[1:0], slow, lcd_en, dma_ie, timer_ie, -}
//   7 R  : {6'b0, dma_pending, timer_pending}
//   other offsets read as 8'hFF; writes to read-only offsets are dropped.

module sys_irq_ctrl #(
    parameter int PRESC_FAST = 255,
    parameter int PRESC_SLOW = 16383
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    input  logic       cs,
    input  logic       we,
    input  logic [2:0] addr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic [7:0] joy,
    input  logic       dma_done,
    output logic       irq,
    output logic [1:0] bank,
    output logic       lcd_en
);

    // Prescaler reload values narrowed once to the counter width.
    localparam logic [13:0] PRESC_FAST_V = 14'(PRESC_FAST);
    localparam logic [13:0] PRESC_SLOW_V = 14'(PRESC_SLOW);

    // Register offsets.
    localparam logic [2:0] OFF_JOY     = 3'd0;
    localparam logic [2:0] OFF_COUNT   = 3'd3;
    localparam logic [2:0] OFF_ACK_TMR = 3'd4;
    localparam logic [2:0] OFF_ACK_DMA = 3'd5;
    localparam logic [2:0] OFF_SYSCTL  = 3'd6;
    localparam logic [2:0] OFF_STATUS  = 3'd7;

    // State flops and their next-state values.
    logic [7:0]  sys_ctl_q, sys_ctl_d;
    logic [7:0]  count_q,   count_d;
    logic [13:0] presc_q,   presc_d;
    logic [1:0]  status_q,  status_d;
    logic [7:0]  dout_q,    dout_d;

    // Decoded bus strobes and timer events.
    logic        rd_acc_s;
    logic        wr_acc_s;
    logic        wr_count_s;
    logic        tick_s;
    logic        timer_set_s;
    logic [13:0] presc_reload_s;

    // Decode CPU accesses; nothing on the bus counts unless ce is high.
    always_comb begin
        rd_acc_s   = ce & cs & ~we;
        wr_acc_s   = ce & cs & we;
        wr_count_s = wr_acc_s & (addr == OFF_COUNT);
    end

    // Prescaler tick fires on the ce cycle where the counter sits at zero;
    // the reload value follows the current speed select bit.
    always_comb begin
        tick_s = ce & (presc_q == 14'd0);
        if (sys_ctl_q[4]) begin
            presc_reload_s = PRESC_SLOW_V;
        end else begin
            presc_reload_s = PRESC_FAST_V;
        end
    end

    // Prescaler: free-running down-counter on ce; a non-zero count write
    // restarts it so the first period after the write is a full one.
    always_comb begin
        presc_d = presc_q;
        if (ce) begin
            if (wr_count_s && (din != 8'h00)) begin
                presc_d = presc_reload_s;
            end else if (presc_q == 14'd0) begin
                presc_d = presc_reload_s;
            end else begin
                presc_d = presc_q - 14'd1;
            end
        end else begin
            presc_d = presc_q;
        end
    end

    // One-shot countdown: a write overrides any tick in the same cycle;
    // once the count is zero it stays there and raises nothing further.
    always_comb begin
        count_d     = count_q;
        timer_set_s = 1'b0;
        if (wr_count_s) begin
            count_d = din;
            if (din == 8'h00) begin
                timer_set_s = 1'b1;
            end else begin
                timer_set_s = 1'b0;
            end
        end else if (tick_s && (count_q != 8'h00)) begin
            count_d = count_q - 8'd1;
            if (count_q == 8'd1) begin
                timer_set_s = 1'b1;
            end else begin
                timer_set_s = 1'b0;
            end
        end else begin
            count_d = count_q;
        end
    end

    // System control register, written only through offset 6.
    always_comb begin
        sys_ctl_d = sys_ctl_q;
        if (wr_acc_s && (addr == OFF_SYSCTL)) begin
            sys_ctl_d = din;
        end else begin
            sys_ctl_d = sys_ctl_q;
        end
    end

    // Status bits: set wins over a read-to-clear in the same cycle so an
    // event coinciding with an acknowledge is never lost. DMA completion
    // is captured on any clk, not only on ce cycles.
    always_comb begin
        status_d    = status_q;
        status_d[0] = timer_set_s |
                      (status_q[0] & ~(rd_acc_s && (addr == OFF_ACK_TMR)));
        status_d[1] = dma_done |
                      (status_q[1] & ~(rd_acc_s && (addr == OFF_ACK_DMA)));
    end

    // Read data mux; the value is captured on the read and held until the
    // next read so the CPU can sample it at leisure.
    always_comb begin
        dout_d = dout_q;
        if (rd_acc_s) begin
            case (addr)
                OFF_JOY:    dout_d = ~joy;
                OFF_COUNT:  dout_d = count_q;
                OFF_SYSCTL: dout_d = sys_ctl_q;
                OFF_STATUS: dout_d = {6'b000000, status_q};
                default:    dout_d = 8'hFF;
            endcase
        end else begin
            dout_d = dout_q;
        end
    end

    // State update; reset aborts any countdown and parks the bus at 8'hFF.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sys_ctl_q <= 8'h00;
            count_q   <= 8'h00;
            presc_q   <= PRESC_FAST_V;
            status_q  <= 2'b00;
            dout_q    <= 8'hFF;
        end else begin
            sys_ctl_q <= sys_ctl_d;
            count_q   <= count_d;
            presc_q   <= presc_d;
            status_q  <= status_d;
            dout_q    <= dout_d;
        end
    end

    // Outputs: irq is a level built from pending status and its enables,
    // so enabling a source with an event already pending raises it at once.
    always_comb begin
        dout   = dout_q;
        irq    = (status_q[0] & sys_ctl_q[1]) | (status_q[1] & sys_ctl_q[2]);
        bank   = sys_ctl_q[6:5];
        lcd_en = sys_ctl_q[3];
    end

endmodule

// File: tb/tb_sys_irq_ctrl.sv
// Directed bench for sys_irq_ctrl. Read expectations are queued when a read
// is issued; a monitor pops and compares when registered read data appears.
// Level outputs (irq, bank, lcd_en) and expiry timing are checked inline.

module tb_sys_irq_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       ce;
    logic       cs;
    logic       we;
    logic [2:0] addr;
    logic [7:0] din;
    logic [7:0] dout;
    logic [7:0] joy;
    logic       dma_done;
    logic       irq;
    logic [1:0] bank;
    logic       lcd_en;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] exp;
        logic [2:0] a;
    } rd_exp_t;

    rd_exp_t exp_q[$];

    always #5 clk = ~clk;

    sys_irq_ctrl #(
        .PRESC_FAST(255),
        .PRESC_SLOW(16383)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ce       (ce),
        .cs       (cs),
        .we       (we),
        .addr     (addr),
        .din      (din),
        .dout     (dout),
        .joy      (joy),
        .dma_done (dma_done),
        .irq      (irq),
        .bank     (bank),
        .lcd_en   (lcd_en)
    );

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, req);
        end
    endtask

    // One bus cycle: drive at negedge, let the posedge take it, return at negedge.
    task automatic cyc(input logic c, input logic s, input logic w,
                       input logic [2:0] a, input logic [7:0] d);
        ce   = c;
        cs   = s;
        we   = w;
        addr = a;
        din  = d;
        @(posedge clk);
        @(negedge clk);
        ce = 1'b0;
        cs = 1'b0;
        we = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        cyc(1'b1, 1'b1, 1'b1, a, d);
    endtask

    task automatic rd(input logic [2:0] a, input logic [7:0] e);
        rd_exp_t item;
        item.exp = e;
        item.a   = a;
        exp_q.push_back(item);
        cyc(1'b1, 1'b1, 1'b0, a, 8'h00);
    endtask

    task automatic ce_pulses(input int n, input int period);
        for (int i = 0; i < n; i++) begin
            for (int k = 1; k < period; k++) cyc(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
            cyc(1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
        end
    endtask

    // Issue ce pulses until irq is seen or the bound expires.
    task automatic wait_irq(input int period, input int limit, output int n, output bit seen);
        n    = 0;
        seen = 1'b0;
        while (!seen && (n < limit)) begin
            for (int k = 1; k < period; k++) cyc(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
            cyc(1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
            n++;
            if (irq === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic check_expiry(input string name, input int n, input bit seen, input int req);
        checks++;
        if (!seen || (n < req - 1) || (n > req + 1)) begin
            errors++;
            $display("FAIL %s: expired after %0d ce (seen=%0d) expected %0d +-1", name, n, seen, req);
        end
    endtask

    task automatic dma_pulse();
        dma_done = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dma_done = 1'b0;
    endtask

    // Read monitor: a read taken at a posedge presents dout by the next negedge.
    initial begin
        logic    fire;
        rd_exp_t e;
        forever begin
            @(posedge clk);
            fire = ce & cs & ~we & ~reset;
            @(negedge clk);
            if (fire) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_unexpected: got %h expected no read", dout);
                end else begin
                    e = exp_q.pop_front();
                    checks++;
                    if (dout !== e.exp) begin
                        errors++;
                        $display("FAIL rd_off%0d: got %h expected %h", e.a, dout, e.exp);
                    end
                end
            end
        end
    end

    initial begin
        int n;
        bit seen;

        reset    = 1'b1;
        ce       = 1'b0;
        cs       = 1'b0;
        we       = 1'b0;
        addr     = 3'd0;
        din      = 8'h00;
        joy      = 8'h00;
        dma_done = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check8("rst_dout", dout, 8'hFF);
        check1("rst_irq", irq, 1'b0);
        check8("rst_bank", {6'b000000, bank}, 8'h00);
        check1("rst_lcd", lcd_en, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        rd(3'd7, 8'h00);
        rd(3'd3, 8'h00);
        rd(3'd6, 8'h00);
        rd(3'd1, 8'hFF);

        // Bus ignored without ce; writes to read-only offsets dropped
        cyc(1'b0, 1'b1, 1'b1, 3'd6, 8'hFF);
        check8("ce0_bank", {6'b000000, bank}, 8'h00);
        wr(3'd7, 8'hFF);
        wr(3'd0, 8'hFF);
        wr(3'd4, 8'hFF);
        rd(3'd7, 8'h00);
        rd(3'd6, 8'h00);

        // Joypad, bank, lcd_en, dout hold
        joy = 8'h81;
        rd(3'd0, 8'h7E);
        joy = 8'h00;
        wr(3'd6, 8'h68);
        check8("bank", {6'b000000, bank}, 8'h03);
        check1("lcd_en", lcd_en, 1'b1);
        rd(3'd6, 8'h68);
        ce_pulses(3, 1);
        check8("dout_hold", dout, 8'h68);

        // Fast countdown, ce every 4 clk: 3 x 256 ce pulses
        wr(3'd6, 8'h02);
        wr(3'd3, 8'h03);
        wait_irq(4, 900, n, seen);
        check_expiry("fast_expiry", n, seen, 768);
        rd(3'd3, 8'h00);
        rd(3'd7, 8'h01);

        // Acknowledge after expiry
        rd(3'd4, 8'hFF);
        check1("ack_irq", irq, 1'b0);
        rd(3'd7, 8'h00);

        // Acknowledge on the same ce as expiry: set wins
        wr(3'd3, 8'h01);
        ce_pulses(255, 1);
        rd(3'd4, 8'hFF);
        check1("ack_race_irq", irq, 1'b1);
        rd(3'd7, 8'h01);
        rd(3'd4, 8'hFF);
        rd(3'd7, 8'h00);

        // Slow prescaler
        wr(3'd6, 8'h12);
        wr(3'd3, 8'h01);
        wait_irq(1, 16500, n, seen);
        check_expiry("slow_expiry", n, seen, 16384);
        rd(3'd4, 8'hFF);
        rd(3'd7, 8'h00);

        // DMA masking, late enable, acknowledge
        wr(3'd6, 8'h02);
        dma_pulse();
        check1("dma_masked_irq", irq, 1'b0);
        rd(3'd7, 8'h02);
        wr(3'd6, 8'h04);
        check1("dma_enable_irq", irq, 1'b1);
        rd(3'd5, 8'hFF);
        check1("dma_ack_irq", irq, 1'b0);
        rd(3'd7, 8'h00);
        dma_done = 1'b1;
        rd(3'd5, 8'hFF);
        dma_done = 1'b0;
        check1("dma_race_irq", irq, 1'b1);
        rd(3'd7, 8'h02);
        rd(3'd5, 8'hFF);
        rd(3'd7, 8'h00);

        // Reset mid-countdown
        wr(3'd6, 8'h06);
        wr(3'd3, 8'h05);
        ce_pulses(300, 1);
        dma_pulse();
        check1("pre_rst_irq", irq, 1'b1);
        rd(3'd6, 8'h06);
        #2;
        reset = 1'b1;
        #1;
        check8("mid_rst_dout", dout, 8'hFF);
        check1("mid_rst_irq", irq, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        wr(3'd6, 8'h02);
        wait_irq(1, 2000, n, seen);
        check1("post_rst_no_expiry", seen, 1'b0);
        rd(3'd7, 8'h00);
        rd(3'd3, 8'h00);
        wr(3'd3, 8'h00);
        check1("zero_write_irq", irq, 1'b1);
        rd(3'd7, 8'h01);

        // All queued reads answered
        repeat (3) @(negedge clk);
        check8("queue_empty", 8'(exp_q.size()), 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sys_irq_ctrl.md
SYS_IRQ_CTRL -- requirements
Module: sys_irq_ctrl

Interface
REQ-001 SHALL have parameter PRESC_FAST, default 255: prescaler reload value when sys_ctl[4]=0.
REQ-002 SHALL have parameter PRESC_SLOW, default 16383: prescaler reload value when sys_ctl[4]=1.
REQ-003 SHALL have port clk, input, 1 bit: single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port ce, input, 1 bit: CPU clock enable, one-cycle pulse per CPU cycle.
REQ-006 SHALL have port cs, input, 1 bit: register select for 2020-2027.
REQ-007 SHALL have port we, input, 1 bit: 1=write, 0=read.
REQ-008 SHALL have port addr, input, 3 bits: register offset.
REQ-009 SHALL have port din, input, 8 bits: CPU write data.
REQ-010 SHALL have port dout, output, 8 bits: registered read data.
REQ-011 SHALL have port joy, input, 8 bits: active-high buttons; bits 7..0 are start, select, A, B, up, down, left, right.
REQ-012 SHALL have port dma_done, input, 1 bit: one-cycle pulse when the audio DMA completes.
REQ-013 SHALL have port irq, output, 1 bit: level IRQ to the CPU.
REQ-014 SHALL have port bank, output, 2 bits: sys_ctl[6:5], the ROM bank at 8000-BFFF.
REQ-015 SHALL have port lcd_en, output, 1 bit: sys_ctl[3].

Function
REQ-016 SHALL define an access as a clk cycle with ce=1 and cs=1; with ce=0, cs and we SHALL be ignored.
REQ-017 SHALL, on a write access to offset 6, load sys_ctl with din.
REQ-018 SHALL, on a read access, register dout and present it on the next clk cycle.
REQ-019 SHALL drive dout on a read as follows:
- offset 0: ~joy
- offset 3: timer count
- offset 6: sys_ctl
- offset 7: {6'b0, status[1:0]}
- any other offset: 8'hFF
REQ-020 SHALL hold dout unchanged between reads.
REQ-021 SHALL implement a 14-bit prescaler that decrements on each ce cycle.
REQ-022 SHALL, when the prescaler reaches 0 (tick), reload it on the next ce cycle with PRESC_SLOW if sys_ctl[4]=1, else PRESC_FAST.
REQ-023 SHALL, on a write access to offset 3 with din≠0, load the 8-bit timer count with din and reload the prescaler; the tick at that ce SHALL be ignored.
REQ-024 SHALL, on a write access to offset 3 with din=0, clear the count and set status[0] on the same edge.
REQ-025 SHALL, on a tick with count>0, decrement the count.
REQ-026 SHALL set status[0] on the tick that moves the count from 1 to 0.
REQ-027 SHALL, with count=0, hold the count at 0 and raise no further timer events (the timer is one-shot).
REQ-028 SHALL clear status[0] on a read access to offset 4.
REQ-029 SHALL set status[1] on dma_done=1, regardless of ce.
REQ-030 SHALL clear status[1] on a read access to offset 5.
REQ-031 SHALL give set priority when a set and a clear of the same status bit occur in the same cycle.
REQ-032 SHALL drive irq combinationally as (status[0] & sys_ctl[1]) | (status[1] & sys_ctl[2]).
REQ-033 SHALL set status bits independent of the enable bits in sys_ctl, so that enabling later raises irq immediately.
REQ-034 SHALL ignore writes to offsets 0, 1, 2, 4, 5 and 7.
REQ-035 SHALL have no side effects on reads of offsets 0, 1, 2, 3, 6 and 7.

Reset
REQ-036 SHALL, while reset=1, asynchronously set:
- sys_ctl=0
- count=0
- prescaler=PRESC_FAST
- status=0
- dout=8'hFF
- therefore irq=0, bank=0, lcd_en=0
REQ-037 SHALL, if reset asserts mid-countdown, abort the countdown and raise no timer event after reset release until offset 3 is written.

Verification
REQ-038 SHALL verify fast countdown:
- stimulus: write sys_ctl=8'h02, then write offset 3 = 3, with ce every 4 clk
- required response: status[0] and irq rise after 3×256 ce pulses ±1; count reads 0.
REQ-039 SHALL verify slow prescaler: with sys_ctl=8'h12 and offset 3 = 1, the timer expires after 16384 ce pulses ±1.
REQ-040 SHALL verify ack:
- stimulus: read offset 4 after expiry
- required response: irq falls on the next clk; offset 7 reads 8'h00.
- stimulus: read offset 4 on the same cycle as an expiry
- required response: status[0] stays 1.
REQ-041 SHALL verify DMA IRQ masking:
- stimulus: pulse dma_done with sys_ctl[2]=0
- required response: irq=0 and offset 7 reads 8'h02.
- stimulus: write sys_ctl=8'h04
- required response: irq=1.
- stimulus: read offset 5
- required response: irq=0.
REQ-042 SHALL verify joypad, bank and lcd_en:
- stimulus: joy=8'h81
- required response: offset 0 reads 8'h7E.
- stimulus: write sys_ctl=8'h68
- required response: bank=2'b11, lcd_en=1.
REQ-043 SHALL verify reset mid-operation:
- stimulus: assert reset during a countdown with count=5
- required response: dout=8'hFF and irq=0 immediately; after release, no expiry within 2000 ce pulses; writing offset 3 = 0 sets status[0] on that edge.
